// File: rtl/sb_monitor_pkg.sv
// sb_monitor_pkg: shared state and failure-code types for the scoreboard monitor.
package sb_monitor_pkg;
    localparam int FC_W = 3;
    typedef enum logic [1:0] {S_IDLE, S_TRACK, S_PASS, S_FAIL} state_t;
    typedef enum logic [FC_W-1:0] {
        FC_NONE     = 3'd0,
        FC_DATA     = 3'd1,
        FC_TIMEOUT  = 3'd2,
        FC_SPURIOUS = 3'd3,
        FC_DUP      = 3'd4
    } fail_code_t;
endpackage

// File: rtl/scoreboard_monitor_sat_counter.sv
// sat_counter: up-counter with synchronous clear that saturates at MAX.
module sat_counter #(
    parameter int WIDTH = 7,
    parameter int MAX   = 64
) (
    input  logic             clk,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_q,
    output logic             o_at_max
);
    logic [WIDTH-1:0] r_q;
    always_ff @(posedge clk) begin
        if (i_clr) r_q <= '0;
        else if (i_en && !o_at_max) r_q <= r_q + 1'b1;
    end
    assign o_q      = r_q;
    assign o_at_max = (r_q == WIDTH'(MAX));
endmodule

// File: rtl/scoreboard_monitor.sv
// scoreboard_monitor: tracks one magic-packet run through the Scoreboard and
// latches a sticky pass/fail verdict with failure code and exit latency.
module scoreboard_monitor
    import sb_monitor_pkg::*;
#(
    parameter int MAX_LAT = 64,
    parameter int LATWID  = $clog2(MAX_LAT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              push,
    input  logic              data_out_vld,
    input  logic              prop_signal,
    input  logic              clear,
    output logic              armed,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [FC_W-1:0]   fail_code,
    output logic [LATWID-1:0] latency
);
    state_t           r_state, w_next;
    fail_code_t       r_code, w_code;
    logic             w_at_max, w_lat_clr, w_lat_en, w_term;
    logic [LATWID-1:0] w_lat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_code  <= FC_NONE;
        end else begin
            r_state <= w_next;
            r_code  <= w_code;
        end
    end

    // data_out_vld outranks capture in IDLE and outranks timeout in TRACK
    always_comb begin
        w_next = r_state;
        w_code = FC_NONE;
        case (r_state)
            S_IDLE: begin
                if (data_out_vld) begin
                    w_next = S_FAIL;
                    w_code = FC_SPURIOUS;
                end else if (start && push) w_next = S_TRACK;
            end
            S_TRACK: begin
                if (data_out_vld && prop_signal) w_next = S_PASS;
                else if (data_out_vld) begin
                    w_next = S_FAIL;
                    w_code = FC_DATA;
                end else if (w_at_max) begin
                    w_next = S_FAIL;
                    w_code = FC_TIMEOUT;
                end
            end
            S_PASS: begin
                if (clear) w_next = S_IDLE;
                else if (data_out_vld) begin
                    w_next = S_FAIL;
                    w_code = FC_DUP;
                end
            end
            default: begin
                w_next = clear ? S_IDLE : S_FAIL;
                w_code = clear ? FC_NONE : r_code;
            end
        endcase
    end

    assign w_term    = (r_state == S_PASS) || (r_state == S_FAIL);
    assign w_lat_clr = rst || (r_state == S_IDLE) || (w_term && clear);
    assign w_lat_en  = (r_state == S_TRACK) && !data_out_vld;

    sat_counter #(.WIDTH(LATWID), .MAX(MAX_LAT)) u_lat (
        .clk      (clk),
        .i_clr    (w_lat_clr),
        .i_en     (w_lat_en),
        .o_q      (w_lat),
        .o_at_max (w_at_max)
    );

    always_comb begin
        armed     = (r_state == S_TRACK);
        done      = w_term;
        pass      = (r_state == S_PASS);
        fail      = (r_state == S_FAIL);
        fail_code = r_code;
        latency   = w_lat;
    end
endmodule

// File: tb/tb_scoreboard_monitor.sv
// tb_scoreboard_monitor: directed table-driven and hand-sequenced checks of scoreboard_monitor.
module tb_scoreboard_monitor;
    localparam int MAX_LAT = 8;
    localparam int LATWID  = 4;

    logic clk = 1'b0;
    logic rst, start, push, data_out_vld, prop_signal, clear;
    logic armed, done, pass, fail;
    logic [2:0] fail_code;
    logic [LATWID-1:0] latency;
    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    scoreboard_monitor #(.MAX_LAT(MAX_LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .push         (push),
        .data_out_vld (data_out_vld),
        .prop_signal  (prop_signal),
        .clear        (clear),
        .armed        (armed),
        .done         (done),
        .pass         (pass),
        .fail         (fail),
        .fail_code    (fail_code),
        .latency      (latency)
    );

    typedef struct {
        logic r, s, p, v, pr, c;
        logic a, d, ps, f;
        logic [2:0] code;
        logic [3:0] lat;
    } vec_t;

    vec_t tbl[$];

    task automatic step(input logic r, s, p, v, pr, c);
        rst = r; start = s; push = p; data_out_vld = v; prop_signal = pr; clear = c;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic a, d, ps, f,
                       input logic [2:0] code, input logic [3:0] lat);
        logic [10:0] got, exp;
        got = {armed, done, pass, fail, fail_code, latency};
        exp = {a, d, ps, f, code, lat};
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got armed=%b done=%b pass=%b fail=%b code=%0d lat=%0d, expected armed=%b done=%b pass=%b fail=%b code=%0d lat=%0d",
                      name, armed, done, pass, fail, fail_code, latency, a, d, ps, f, code, lat);
    endtask

    task automatic idle_step(input string name, input logic a, d, ps, f,
                             input logic [2:0] code, input logic [3:0] lat);
        step(0, 0, 0, 0, 0, 0);
        chk(name, a, d, ps, f, code, lat);
    endtask

    initial begin
        //        r  s  p  v  pr c    a  d  ps f  code  lat
        tbl.push_back('{1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 3'd0, 4'd0}); // reset
        tbl.push_back('{0, 1, 1, 0, 0, 0,  1, 0, 0, 0, 3'd0, 4'd0}); // capture
        tbl.push_back('{0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 3'd0, 4'd1});
        tbl.push_back('{0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 3'd0, 4'd2}); // clear ignored in TRACK
        tbl.push_back('{0, 0, 0, 1, 1, 0,  0, 1, 1, 0, 3'd0, 4'd2}); // pass
        tbl.push_back('{0, 0, 0, 1, 0, 0,  0, 1, 0, 1, 3'd4, 4'd2}); // duplicate
        tbl.push_back('{0, 1, 1, 0, 0, 0,  0, 1, 0, 1, 3'd4, 4'd2}); // start ignored in FAIL
        tbl.push_back('{0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 3'd0, 4'd0}); // clear from FAIL
        tbl.push_back('{0, 1, 1, 1, 1, 0,  0, 1, 0, 1, 3'd3, 4'd0}); // spurious beats capture
        tbl.push_back('{0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 3'd0, 4'd0});
        tbl.push_back('{0, 1, 1, 0, 0, 0,  1, 0, 0, 0, 3'd0, 4'd0});
        tbl.push_back('{0, 0, 0, 0, 1, 0,  1, 0, 0, 0, 3'd0, 4'd1}); // prop without vld
        tbl.push_back('{0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 3'd0, 4'd2});
        tbl.push_back('{0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 3'd0, 4'd3});
        tbl.push_back('{0, 0, 0, 1, 0, 0,  0, 1, 0, 1, 3'd1, 4'd3}); // data mismatch
        tbl.push_back('{0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 3'd0, 4'd0});
        tbl.push_back('{0, 0, 0, 1, 0, 0,  0, 1, 0, 1, 3'd3, 4'd0}); // spurious alone
        tbl.push_back('{1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 3'd0, 4'd0});
        tbl.push_back('{0, 1, 1, 0, 0, 0,  1, 0, 0, 0, 3'd0, 4'd0});
        tbl.push_back('{0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 3'd0, 4'd1});
        tbl.push_back('{1, 1, 1, 1, 1, 1,  0, 0, 0, 0, 3'd0, 4'd0}); // rst mid-TRACK wins
        tbl.push_back('{0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 3'd0, 4'd0}); // start without push
        tbl.push_back('{0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 3'd0, 4'd0}); // push without start
        tbl.push_back('{0, 1, 1, 0, 0, 0,  1, 0, 0, 0, 3'd0, 4'd0});
        tbl.push_back('{0, 0, 0, 1, 1, 0,  0, 1, 1, 0, 3'd0, 4'd0}); // immediate exit
        tbl.push_back('{0, 0, 0, 1, 0, 1,  0, 0, 0, 0, 3'd0, 4'd0}); // clear beats dup in PASS
        tbl.push_back('{0, 1, 1, 0, 0, 0,  1, 0, 0, 0, 3'd0, 4'd0}); // new run accepted
        tbl.push_back('{1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 3'd0, 4'd0});

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].s, tbl[i].p, tbl[i].v, tbl[i].pr, tbl[i].c);
            chk($sformatf("vec%0d", i), tbl[i].a, tbl[i].d, tbl[i].ps, tbl[i].f, tbl[i].code, tbl[i].lat);
        end

        // pass run: capture, six quiet TRACK cycles, exit reports latency 6
        step(0, 1, 1, 0, 0, 0);
        chk("run_cap", 1, 0, 0, 0, 3'd0, 4'd0);
        for (int k = 1; k <= 6; k++) idle_step($sformatf("run_trk%0d", k), 1, 0, 0, 0, 3'd0, 4'(k));
        step(0, 0, 0, 1, 1, 0);
        chk("run_pass", 0, 1, 1, 0, 3'd0, 4'd6);
        idle_step("run_hold", 0, 1, 1, 0, 3'd0, 4'd6);
        step(0, 0, 0, 0, 0, 1);
        chk("run_clear", 0, 0, 0, 0, 3'd0, 4'd0);

        // timeout: latency climbs to MAX_LAT then the run fails with TIMEOUT
        step(0, 1, 1, 0, 0, 0);
        chk("to_cap", 1, 0, 0, 0, 3'd0, 4'd0);
        for (int k = 1; k <= MAX_LAT; k++) idle_step($sformatf("to_trk%0d", k), 1, 0, 0, 0, 3'd0, 4'(k));
        idle_step("to_fail", 0, 1, 0, 1, 3'd2, 4'd8);
        idle_step("to_hold", 0, 1, 0, 1, 3'd2, 4'd8);
        step(0, 1, 1, 1, 1, 0);
        chk("to_sticky", 0, 1, 0, 1, 3'd2, 4'd8);
        step(0, 0, 0, 0, 0, 1);
        chk("to_clear", 0, 0, 0, 0, 3'd0, 4'd0);

        // exit on the cycle latency == MAX_LAT is still a pass
        step(0, 1, 1, 0, 0, 0);
        chk("edge_cap", 1, 0, 0, 0, 3'd0, 4'd0);
        for (int k = 1; k <= MAX_LAT; k++) idle_step($sformatf("edge_trk%0d", k), 1, 0, 0, 0, 3'd0, 4'(k));
        step(0, 0, 0, 1, 1, 0);
        chk("edge_pass", 0, 1, 1, 0, 3'd0, 4'd8);
        step(0, 0, 0, 1, 1, 0);
        chk("edge_dup", 0, 1, 0, 1, 3'd4, 4'd8);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/scoreboard_monitor.md
Name: scoreboard_monitor

Overview:
- Downstream consumer of the Scoreboard outputs `data_out_vld` and `prop_signal`, plus the Scoreboard's `start` and `push[0]` stimulus.
- Turns the per-cycle property into a verdict: tracks a single magic-packet run, measures its exit latency, and enforces a liveness bound.
- Latches a sticky pass/fail result with a failure code.
- Used in simulation benches and as the formal liveness/safety wrapper around the Scoreboard.

Parameters:
- MAX_LAT, 64: maximum cycles allowed from capture to exit before the run is a timeout failure.
- LATWID, $clog2(MAX_LAT+1): width of the latency counter and of the `latency` output.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; one clock, synchronous, active-high.
- start  input  1  same signal driven to the Scoreboard `start`.
- push  input  1  same signal as Scoreboard `push[0]`.
- data_out_vld  input  1  Scoreboard `data_out_vld`.
- prop_signal  input  1  Scoreboard `prop_signal`.
- clear  input  1  soft return to IDLE from a terminal state.
- armed  output  1  run in progress (state TRACK).
- done  output  1  terminal state reached (sticky).
- pass  output  1  run completed with correct data.
- fail  output  1  any failure.
- fail_code  output  3  0 NONE, 1 DATA, 2 TIMEOUT, 3 SPURIOUS, 4 DUP.
- latency  output  LATWID  cycles from capture to exit, frozen at terminal state.

Behaviour:
- All outputs are registered. On rst:
  - state = IDLE;
  - armed, done, pass and fail = 0;
  - fail_code = 0;
  - latency = 0.
- rst asserted mid-run aborts unconditionally to IDLE; it has priority over every other input.
- States: IDLE, TRACK, PASS, FAIL. done = PASS or FAIL; pass = (state == PASS); fail = (state == FAIL).
- Transitions out of IDLE (first matching rule wins):
  - data_out_vld = 1 -> FAIL with SPURIOUS. This holds even if `start & push` is asserted in the same cycle.
  - start & push -> TRACK, with latency = 0. This is the Scoreboard capture cycle.
  - otherwise stay in IDLE.
- Transitions out of TRACK, evaluated each cycle (first matching rule wins):
  - data_out_vld & prop_signal -> PASS.
  - data_out_vld & ~prop_signal -> FAIL with DATA.
  - latency == MAX_LAT -> FAIL with TIMEOUT.
  - otherwise latency increments by 1.
- An exit in the same cycle that latency == MAX_LAT is a PASS (data_out_vld wins over timeout).
- Latency counting:
  - Latency counts the cycles in TRACK before the exit cycle. An exit on the first cycle after capture reports latency = 0.
  - Latency saturates at MAX_LAT and never wraps.
- PASS: data_out_vld = 1 -> FAIL with DUP. The magic packet exits exactly once, so a second exit is a duplicate.
- FAIL: sticky; fail_code and latency hold.
- clear:
  - Takes effect only in PASS or FAIL: -> IDLE, all outputs cleared the next cycle.
  - Ignored in IDLE and TRACK.
  - If clear and data_out_vld arrive in the same cycle in PASS, clear wins.
- start/push while in TRACK, PASS or FAIL are ignored; the monitor handles only one run per clear/reset.
- fail_code is written only on the transition into FAIL and holds 0 in every other state.

Decomposition:
- Package sb_monitor_pkg holds:
  - the state enum (IDLE, TRACK, PASS, FAIL);
  - the fail_code enum (NONE = 0 .. DUP = 4) and the fail_code width constant (3).
- One natural sub-module, sat_counter (parameters WIDTH and MAX), implements the latency counter:
  - synchronous clear;
  - increment enable;
  - saturation at MAX;
  - an `at_max` flag output.

Test Plan:
- Pass run: start=1, push=1 at cycle 5; data_out_vld=1 with prop_signal=1 at cycle 12 -> armed 1 on cycles 6-12; pass=1 and done=1 from cycle 13; latency=6; fail_code=0.
- Data mismatch: arm, then at the 4th TRACK cycle drive data_out_vld=1, prop_signal=0 -> fail=1, fail_code=1, latency=3.
- Timeout with MAX_LAT=8: arm with no exit -> fail=1, fail_code=2, latency=8, 9 cycles after capture. Repeat with the exit on the cycle latency==8 -> pass=1, latency=8.
- Spurious and duplicate:
  - data_out_vld=1 in IDLE, including together with start&push -> fail_code=3.
  - After a PASS, drive data_out_vld=1 once more -> fail_code=4.
- Clear and reset:
  - clear during TRACK -> ignored; the run still completes.
  - clear in PASS -> IDLE next cycle with all outputs 0; a new run is accepted.
  - rst pulsed in mid-TRACK -> IDLE with all outputs 0 the next cycle.
